clk_set_button: RTL

Conditions the raw "set/advance" push-button of the clock into the single-cycle `i_add` strobe consumed by the minute/hour counters. Provides a two-flop synchronizer, tick-based debounce, and hold-to-auto-repeat, so a held button keeps advancing the counter at a fixed rate. Sits directly upstream of the time counters and is driven by the board button plus the shared millisecond tick.

---
 rtl/clk_set_button.sv | 125 ++++++++++++
 1 files changed

// File: rtl/clk_set_button.sv
// Set/advance button conditioner: two-flop synchronizer, tick-based debounce and
// hold-to-auto-repeat, producing a single-cycle advance strobe for the time counters.
module clk_set_button #(
  parameter int DB_TICKS   = 20,
  parameter int REP_DELAY  = 500,
  parameter int REP_PERIOD = 100,
  parameter int CW         = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_tick,
  input  logic i_set_mode,
  output logic o_add,
  output logic o_held
);

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic          sync1_reg;
  logic          s_btn;
  logic          stable_reg, stable_next;
  logic [CW-1:0] db_cnt_reg, db_cnt_next;
  logic [CW-1:0] rep_cnt_reg, rep_cnt_next;
  state_t        state_reg, state_next;
  logic          fire;
  logic          add_reg;

  // Debounce: count ticks while the synchronized level disagrees with the accepted one.
  always_comb begin
    stable_next = stable_reg;
    db_cnt_next = '0;
    if (s_btn != stable_reg) begin
      db_cnt_next = db_cnt_reg;
      if (i_tick) begin
        if (db_cnt_reg == DB_LAST) begin
          stable_next = s_btn;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt_reg + CW'(1);
        end
      end
    end
  end

  // Decisions use stable_next so the first pulse lines up with o_held rising and a
  // release that coincides with a repeat expiry suppresses that pulse.
  always_comb begin
    state_next   = state_reg;
    rep_cnt_next = rep_cnt_reg;
    fire         = 1'b0;
    case (state_reg)
      IDLE: begin
        rep_cnt_next = '0;
        if (stable_next && !stable_reg) begin
          fire       = 1'b1;
          state_next = DELAY;
        end
      end
      DELAY: begin
        if (!stable_next) begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end else if (i_tick) begin
          if (rep_cnt_reg == DLY_LAST) begin
            fire         = 1'b1;
            rep_cnt_next = '0;
            state_next   = REPEAT;
          end else begin
            rep_cnt_next = rep_cnt_reg + CW'(1);
          end
        end
      end
      REPEAT: begin
        if (!stable_next) begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end else if (i_tick) begin
          if (rep_cnt_reg == PER_LAST) begin
            fire         = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next   = IDLE;
        rep_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= 1'b0;
      s_btn       <= 1'b0;
      stable_reg  <= 1'b0;
      db_cnt_reg  <= '0;
      rep_cnt_reg <= '0;
      state_reg   <= IDLE;
      add_reg     <= 1'b0;
    end else begin
      sync1_reg   <= i_btn;
      s_btn       <= sync1_reg;
      stable_reg  <= stable_next;
      db_cnt_reg  <= db_cnt_next;
      rep_cnt_reg <= rep_cnt_next;
      state_reg   <= state_next;
      add_reg     <= fire & i_set_mode;
    end
  end

  assign o_add  = add_reg;
  assign o_held = stable_reg;

endmodule
